// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and defaults for the divided-clock monitor
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    MEAS   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam int DEF_CNT_W       = 26;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with history flop and edge strobes
module sync_edge
  import clk_div_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  // Resetting to 0 means a line already high at release still yields one rise.
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - edge ticks, period measurement, lock and timeout for a divided clock
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int               SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int               CNT_W       = DEF_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT     = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rise;
  logic             fall;
  logic             div_level_unused;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (div_in),
    .level(div_level_unused),
    .rise (rise),
    .fall (fall)
  );

  // Loading 1 on a rise makes cnt equal the rise-to-rise distance at the next rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tick_rise    <= 1'b0;
      tick_fall    <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      tick_rise    <= rise;
      tick_fall    <= fall;
      period_valid <= 1'b0;
      if (rise) begin
        // A rise on the threshold cycle takes precedence over the timeout.
        timeout <= 1'b0;
        case (state)
          IDLE: begin
            state  <= ARMED;
            locked <= 1'b0;
          end
          ARMED: begin
            state        <= MEAS;
            period       <= cnt;
            period_valid <= 1'b1;
            locked       <= 1'b0;
          end
          MEAS, LOCKED: begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (cnt == period) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              state  <= MEAS;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end else if (state != IDLE && cnt == TIMEOUT) begin
        state   <= IDLE;
        locked  <= 1'b0;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor
module tb_clk_div_monitor;

  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             div_in = 1'b0;
  logic             tick_rise;
  logic             tick_fall;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  clk_div_monitor #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .TIMEOUT    (26'd20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .div_in      (div_in),
    .tick_rise   (tick_rise),
    .tick_fall   (tick_fall),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int ph = 0;
  int per = 8;
  int half = 4;
  bit gen_on = 1'b0;
  int falls = 0;
  int n = 0;
  int rises = 0;
  int first = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tick_rise"}, 32'(tick_rise), 0);
    chk({tag, ".tick_fall"}, 32'(tick_fall), 0);
    chk({tag, ".period"}, 32'(period), 0);
    chk({tag, ".period_valid"}, 32'(period_valid), 0);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".timeout"}, 32'(timeout), 0);
  endtask

  // One clk cycle: drive div_in from the synchronous divider model, then sample after the edge.
  task automatic step();
    if (gen_on) begin
      div_in = (ph < half);
      ph = (ph + 1 >= per) ? 0 : ph + 1;
    end
    @(posedge clk);
    #1;
    if (tick_fall) falls++;
  endtask

  task automatic wait_rise(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!tick_rise && cycles < 200);
    chk("rise_seen", 32'(tick_rise), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    gen_on = 1'b1; ph = 0; per = 8; half = 4;
    wait_rise(n);
    chk("lat_first_rise", 32'(n), 3);
    chk("first_rise_pv", 32'(period_valid), 0);
    chk("first_rise_locked", 32'(locked), 0);
    falls = 0;
    wait_rise(n);
    chk("rise2_cycles", 32'(n), 8);
    chk("rise2_period", 32'(period), 8);
    chk("rise2_pv", 32'(period_valid), 1);
    chk("rise2_locked", 32'(locked), 0);
    chk("one_fall", 32'(falls), 1);
    step();
    chk("pv_one_cycle", 32'(period_valid), 0);
    chk("tick_one_cycle", 32'(tick_rise), 0);
    wait_rise(n);
    chk("rise3_locked", 32'(locked), 1);
    chk("rise3_period", 32'(period), 8);
    chk("rise3_pv", 32'(period_valid), 1);

    per = 16; half = 8;
    wait_rise(n);
    chk("chg_cycles", 32'(n), 16);
    chk("chg_period", 32'(period), 16);
    chk("chg_unlock", 32'(locked), 0);
    chk("chg_pv", 32'(period_valid), 1);
    wait_rise(n);
    chk("chg_relock", 32'(locked), 1);
    chk("chg_relock_period", 32'(period), 16);

    per = 8; half = 4;
    wait_rise(n);
    chk("back8_period", 32'(period), 8);
    chk("back8_unlock", 32'(locked), 0);
    wait_rise(n);
    chk("back8_relock", 32'(locked), 1);

    gen_on = 1'b0; div_in = 1'b0;
    repeat (19) step();
    chk("to_before", 32'(timeout), 0);
    chk("to_before_locked", 32'(locked), 1);
    step();
    chk("to_set", 32'(timeout), 1);
    chk("to_locked", 32'(locked), 0);
    chk("to_period", 32'(period), 8);
    chk("to_pv", 32'(period_valid), 0);

    gen_on = 1'b1; ph = 0; per = 8; half = 4;
    wait_rise(n);
    chk("to_clear", 32'(timeout), 0);
    chk("to_clear_pv", 32'(period_valid), 0);
    chk("to_clear_locked", 32'(locked), 0);
    wait_rise(n);
    chk("rearm_pv", 32'(period_valid), 1);
    chk("rearm_period", 32'(period), 8);
    wait_rise(n);
    chk("rearm_locked", 32'(locked), 1);

    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk_zero("reset_mid");
    gen_on = 1'b0; div_in = 1'b0;
    step();
    step();
    rst = 1'b1;
    gen_on = 1'b1; ph = 0; per = 8; half = 4;
    wait_rise(n);
    chk("post_rst_rise1_pv", 32'(period_valid), 0);
    chk("post_rst_rise1_locked", 32'(locked), 0);
    wait_rise(n);
    chk("post_rst_rise2_pv", 32'(period_valid), 1);
    chk("post_rst_rise2_period", 32'(period), 8);

    per = 20; half = 10;
    wait_rise(n);
    chk("thr_cycles", 32'(n), 20);
    chk("thr_period", 32'(period), 20);
    chk("thr_pv", 32'(period_valid), 1);
    chk("thr_timeout", 32'(timeout), 0);

    rst = 1'b0; gen_on = 1'b0; div_in = 1'b1;
    step();
    step();
    rst = 1'b1;
    falls = 0; rises = 0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (tick_rise) begin
        rises++;
        if (first == 0) first = i;
      end
    end
    chk("hi_rel_latency", 32'(first), 3);
    chk("hi_rel_rises", 32'(rises), 1);
    chk("hi_rel_falls", 32'(falls), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
